// File: rtl/processor_multicycle_pkg.sv
// Shared types and encodings for the multicycle RV-subset core.
package proc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    localparam logic [6:0]  OP_RTYPE   = 7'b0110011;
    localparam logic [6:0]  OP_ITYPE   = 7'b0010011;
    localparam logic [31:0] INSN_ECALL = 32'h0000_0073;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Map funct3 (plus the funct7[5] "alternate" bit) onto an ALU operation.
    function automatic alu_op_t f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/processor_multicycle_if.sv
// Instruction-memory fetch bus between the core (master) and memory (slave).
interface processor_multicycle_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );
endinterface

// File: rtl/processor_multicycle_alu.sv
// Purely combinational integer ALU for the multicycle core.
module alu_rv
    import proc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    // Select the operation result; compares yield 0/1 zero-extended.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y[0] = ($signed(a) < $signed(b));
            ALU_SLTU: y[0] = (a < b);
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/processor_multicycle.sv
// Multicycle FETCH/DECODE/EXEC/WB core with register file and decode.
module processor_multicycle
    import proc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int PC_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    processor_multicycle_if.master imem,
    output logic [XLEN-1:0]        result,
    output logic                   zero,
    output logic                   halted,
    output logic                   illegal,
    output logic [31:0]            retired
);
    localparam int RIW = $clog2(NREGS);
    localparam int SHW = $clog2(XLEN);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    alu_op_t         op_q;
    logic            legal_q;
    logic            req_q;

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [RIW-1:0]  rs1_idx;
    logic [RIW-1:0]  rs2_idx;
    logic [RIW-1:0]  rd_idx;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic            shift_hi_zero;
    alu_op_t         dec_op;
    logic            dec_legal;
    logic            dec_use_imm;
    logic [XLEN-1:0] alu_y;
    logic            rf_we;

    assign opcode  = ir[6:0];
    assign f3      = ir[14:12];
    assign f7      = ir[31:25];
    assign rs1_idx = ir[15 +: RIW];
    assign rs2_idx = ir[20 +: RIW];
    assign rd_idx  = ir[7 +: RIW];
    assign imm_i   = {{(XLEN-12){ir[31]}}, ir[31:20]};

    // Shift immediates: everything above the shamt field must be zero,
    // except bit 30 which selects SRAI.
    assign shift_hi_zero = !ir[31] && (ir[29:20+SHW] == '0);

    assign rs1_val = (rs1_idx == '0) ? '0 : regs[rs1_idx];
    assign rs2_val = (rs2_idx == '0) ? '0 : regs[rs2_idx];

    // Decode the IR into an ALU operation, operand source and legality.
    always_comb begin
        dec_op      = ALU_ADD;
        dec_legal   = 1'b0;
        dec_use_imm = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_op = f3_to_op(f3, f7[5]);
                if (f7 == F7_BASE) begin
                    dec_legal = 1'b1;
                end else if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) begin
                    dec_legal = 1'b1;
                end
            end
            OP_ITYPE: begin
                dec_use_imm = 1'b1;
                case (f3)
                    F3_SLL: begin
                        dec_op    = ALU_SLL;
                        dec_legal = shift_hi_zero && !ir[30];
                    end
                    F3_SR: begin
                        dec_op    = ir[30] ? ALU_SRA : ALU_SRL;
                        dec_legal = shift_hi_zero;
                    end
                    default: begin
                        dec_op    = f3_to_op(f3, 1'b0);
                        dec_legal = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    alu_rv #(.XLEN(XLEN)) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    assign rf_we = (state == WB) && legal_q && (rd_idx != '0);

    // Register file: cleared on reset, written from result during WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we) begin
            regs[rd_idx] <= result;
        end
    end

    // Sequencing FSM with registered datapath and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ALU_ADD;
            legal_q <= 1'b0;
            result  <= '0;
            retired <= '0;
            illegal <= 1'b0;
            halted  <= 1'b0;
            req_q   <= 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_valid) begin
                        ir    <= imem.imem_data;
                        req_q <= 1'b0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (ir == INSN_ECALL) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        a_q     <= rs1_val;
                        b_q     <= dec_use_imm ? imm_i : rs2_val;
                        op_q    <= dec_op;
                        legal_q <= dec_legal;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    result <= alu_y;
                    state  <= WB;
                end
                WB: begin
                    pc      <= pc + PC_W'(4);
                    retired <= retired + 32'd1;
                    if (!legal_q) begin
                        illegal <= 1'b1;
                    end
                    req_q   <= 1'b1;
                    state   <= FETCH;
                end
                default: ;
            endcase
        end
    end

    // The request flop is preset by reset; gating with rst keeps the request
    // low throughout reset yet high on the first cycle after release.
    assign imem.imem_req  = req_q && !rst;
    assign imem.imem_addr = pc;
    assign zero           = (result == '0);

endmodule

// File: tb/tb_processor_multicycle.sv
// Directed scoreboard bench for processor_multicycle (XLEN=32 defaults).
module tb_processor_multicycle;

    typedef struct {
        logic [31:0] res;
        logic        chk;
        logic        ill;
        logic [31:0] ret;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result;
    logic        zero;
    logic        halted;
    logic        illegal;
    logic [31:0] retired;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cycles   = 0;
    logic [15:0] exp_pc   = '0;
    logic [31:0] exp_ret  = '0;
    sb_t         sb[$];

    processor_multicycle_if #(.PC_W(16)) imem_bus ();

    processor_multicycle #(
        .XLEN  (32),
        .NREGS (32),
        .PC_W  (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .imem    (imem_bus),
        .result  (result),
        .zero    (zero),
        .halted  (halted),
        .illegal (illegal),
        .retired (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycles <= cycles + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3, input int rd);
        logic [11:0] im;
        im = imm[11:0];
        return {im, 5'(rs1), f3, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    // Feed one instruction from a FETCH-state negedge, holding valid low for
    // 'waits' cycles, then compare against the scoreboard once it retires.
    task automatic issue(input logic [31:0] ins, input int waits, input logic [31:0] exp_res,
                         input logic chk_res, input logic exp_ill);
        sb_t e;
        logic [31:0] r0;
        sb.push_back('{res: exp_res, chk: chk_res, ill: exp_ill, ret: exp_ret + 32'd1});
        check("fetch_addr", {imem_bus.imem_req, imem_bus.imem_addr}, {1'b1, exp_pc});
        r0 = retired;
        for (int i = 0; i < waits; i++) begin
            imem_bus.imem_valid = 1'b0;
            imem_bus.imem_data  = 32'h0;
            @(negedge clk);
            check("wait_req", imem_bus.imem_req, 1'b1);
        end
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_data  = ins;
        @(negedge clk);
        check("decode_req_low", imem_bus.imem_req, 1'b0);
        // Valid stays high with junk data outside FETCH; it must be ignored.
        imem_bus.imem_data = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        if (retired === r0 + 32'd1 && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                check("result", result, e.res);
                check("zero", zero, (e.res == 32'd0));
            end
            check("illegal", illegal, e.ill);
            check("retired", retired, e.ret);
        end else begin
            check("retire_timeout", retired, r0 + 32'd1);
            if (sb.size() > 0) e = sb.pop_front();
        end
        exp_ret = exp_ret + 32'd1;
        exp_pc  = exp_pc + 16'd4;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, imem_bus.imem_req, 1'b0);
        check({tag, "_state"}, {imem_bus.imem_addr, result, retired, halted, illegal},
              {16'h0, 32'h0, 32'h0, 1'b0, 1'b0});
    endtask

    initial begin
        int          c0;
        logic [31:0] rfz;

        // Reset with a valid instruction offered at the same time.
        rst = 1'b1;
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_data  = enc_i(1, 0, 3'b000, 1);
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        imem_bus.imem_valid = 1'b0;
        #1;
        check("req_after_reset", imem_bus.imem_req, 1'b1);

        // Three-instruction program: 12 cycles with no wait states.
        c0 = cycles;
        issue(enc_i(5, 0, 3'b000, 1), 0, 32'd5, 1'b1, 1'b0);
        issue(enc_i(-3, 0, 3'b000, 2), 0, 32'hFFFF_FFFD, 1'b1, 1'b0);
        issue(enc_r(7'h00, 2, 1, 3'b000, 3), 0, 32'd2, 1'b1, 1'b0);
        check("cycles_3_insns", cycles - c0, 12);

        issue(enc_r(7'h20, 1, 1, 3'b000, 4), 0, 32'd0, 1'b1, 1'b0);
        issue(enc_r(7'h00, 1, 2, 3'b010, 5), 0, 32'd1, 1'b1, 1'b0);
        issue(enc_r(7'h00, 1, 2, 3'b011, 5), 0, 32'd0, 1'b1, 1'b0);
        issue(enc_i(-16, 0, 3'b000, 6), 0, 32'hFFFF_FFF0, 1'b1, 1'b0);
        issue(enc_i('h402, 6, 3'b101, 7), 0, 32'hFFFF_FFFC, 1'b1, 1'b0);
        issue(enc_i(28, 6, 3'b101, 7), 0, 32'h0000_000F, 1'b1, 1'b0);
        issue(enc_i(3, 1, 3'b001, 8), 0, 32'h28, 1'b1, 1'b0);
        issue(enc_i('hFF, 1, 3'b100, 9), 0, 32'hFA, 1'b1, 1'b0);
        issue(enc_i('h100, 9, 3'b110, 9), 0, 32'h1FA, 1'b1, 1'b0);
        issue(enc_i('h0F0, 9, 3'b111, 10), 0, 32'hF0, 1'b1, 1'b0);
        issue(enc_i(-2, 2, 3'b010, 11), 0, 32'd1, 1'b1, 1'b0);
        issue(enc_i(-1, 1, 3'b011, 11), 0, 32'd1, 1'b1, 1'b0);
        issue(enc_r(7'h00, 1, 1, 3'b001, 12), 0, 32'hA0, 1'b1, 1'b0);
        issue(enc_r(7'h20, 1, 6, 3'b101, 13), 0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(enc_r(7'h00, 1, 6, 3'b101, 13), 0, 32'h07FF_FFFF, 1'b1, 1'b0);
        issue(enc_r(7'h00, 2, 1, 3'b110, 14), 0, 32'hFFFF_FFFD, 1'b1, 1'b0);
        issue(enc_r(7'h00, 2, 1, 3'b111, 14), 0, 32'd5, 1'b1, 1'b0);
        issue(enc_r(7'h00, 2, 1, 3'b100, 14), 0, 32'hFFFF_FFF8, 1'b1, 1'b0);

        // Three wait cycles in FETCH: seven cycles total.
        c0 = cycles;
        issue(enc_r(7'h00, 1, 14, 3'b000, 15), 3, 32'hFFFF_FFFD, 1'b1, 1'b0);
        check("cycles_wait3", cycles - c0, 7);
        issue(enc_r(7'h20, 1, 0, 3'b000, 16), 0, 32'hFFFF_FFFB, 1'b1, 1'b0);

        // x0 discards writes; illegal encodings skip writeback but retire.
        issue(enc_i(9, 0, 3'b000, 0), 0, 32'd9, 1'b1, 1'b0);
        issue(enc_r(7'h00, 0, 0, 3'b000, 1), 0, 32'd0, 1'b1, 1'b0);
        issue(32'h0000_0000, 0, 32'd0, 1'b0, 1'b1);
        issue(enc_r(7'h01, 1, 1, 3'b000, 3), 0, 32'd0, 1'b0, 1'b1);
        issue(enc_r(7'h00, 0, 3, 3'b000, 18), 0, 32'd2, 1'b1, 1'b1);

        // ECALL halts; fetch stops and retired freezes regardless of valid.
        check("ecall_addr", imem_bus.imem_addr, exp_pc);
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_data  = 32'h0000_0073;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("halt_hold", {halted, imem_bus.imem_req, retired}, {1'b1, 1'b0, exp_ret});
            imem_bus.imem_data = enc_i(i, 0, 3'b000, 1);
            @(negedge clk);
        end

        // Reset pulse leaves HALT and clears the register file.
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("halt_reset");
        rst = 1'b0;
        imem_bus.imem_valid = 1'b0;
        exp_pc  = '0;
        exp_ret = '0;
        #1;
        check("req_after_halt_reset", imem_bus.imem_req, 1'b1);
        rfz = 32'd0;
        issue(enc_r(7'h00, 0, 3, 3'b000, 2), 0, rfz, 1'b1, 1'b0);
        issue(enc_i(7, 0, 3'b000, 1), 0, 32'd7, 1'b1, 1'b0);

        // Reset during a fetch wait, coinciding with valid: reset wins.
        imem_bus.imem_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midfetch_req", imem_bus.imem_req, 1'b1);
        rst = 1'b1;
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_data  = enc_i(1, 0, 3'b000, 9);
        @(negedge clk);
        check_reset_state("midfetch_reset");
        rst = 1'b0;
        imem_bus.imem_valid = 1'b0;
        exp_pc  = '0;
        exp_ret = '0;
        #1;
        issue(enc_r(7'h00, 0, 1, 3'b000, 2), 0, 32'd0, 1'b1, 1'b0);
        issue(enc_r(7'h00, 0, 9, 3'b000, 3), 1, 32'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/processor_multicycle.md
PROCESSOR_MULTICYCLE -- requirements
Module: processor_multicycle

Interface
REQ-001 Parameter XLEN, default 32: datapath, register and result width; legal values are 32 or 64.
REQ-002 Parameter NREGS, default 32: register count; power of two, 2..32; rs/rd index bits above log2(NREGS) are ignored.
REQ-003 Parameter PC_W, default 16: width of the byte-address program counter.
REQ-004 Port clk, input, 1: the single clock; every flop updates on its rising edge.
REQ-005 Port rst, input, 1: reset; synchronous and active-high.
REQ-006 Port imem_req, output, 1: instruction fetch request.
REQ-007 Port imem_addr, output, PC_W: fetch byte address, equal to the PC.
REQ-008 Port imem_valid, input, 1: instruction data valid.
REQ-009 Port imem_data, input, 32: instruction word.
REQ-010 Port result, output, XLEN: registered ALU result of the last executed instruction.
REQ-011 Port zero, output, 1: high when result == 0.
REQ-012 Port halted, output, 1: high when the core has stopped on ECALL.
REQ-013 Port illegal, output, 1: sticky flag set by an unsupported instruction.
REQ-014 Port retired, output, 32: count of instructions that have completed writeback; wraps modulo 2^32.

Function
REQ-015 The FSM SHALL have five states: FETCH, DECODE, EXEC, WB and HALT.
REQ-016 In FETCH, imem_req SHALL be held high until imem_valid is seen high; imem_data is then latched into the IR and the FSM moves to DECODE.
REQ-017 imem_valid SHALL be ignored in every state except FETCH.
REQ-018 In DECODE, rs1/rs2 SHALL be read into A/B, and the sign-extended 12-bit I-immediate SHALL replace B for opcode 0010011.
REQ-019 In EXEC, the ALU output SHALL be registered into result.
REQ-020 In WB, rd SHALL be written when rd != 0; PC SHALL advance by 4 (mod 2^PC_W); retired SHALL increment; the FSM then returns to FETCH.
REQ-021 Each instruction SHALL take 4 cycles when imem_valid is already high in its FETCH cycle, plus 1 cycle per wait cycle.
REQ-022 R-type (0110011) operations SHALL be ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, selected by funct3 and funct7[5].
REQ-023 I-type operations SHALL be ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
REQ-024 Shift amount SHALL be the low log2(XLEN) bits of B; SRA/SRAI SHALL be arithmetic.
REQ-025 SLT SHALL compare signed; SLTU SHALL compare unsigned; both SHALL produce 0 or 1 zero-extended to XLEN.
REQ-026 Add and subtract SHALL wrap modulo 2^XLEN; no overflow flag is produced.
REQ-027 Register x0 SHALL always read 0; writes to x0 SHALL be discarded.
REQ-028 A DECODE read of a register written in the previous WB SHALL return the new value (no hazard, because the machine is sequential).
REQ-029 An unsupported opcode, funct combination or funct7 SHALL set illegal and SHALL skip the register write, but SHALL still advance PC and increment retired.
REQ-030 Instruction 0x00000073 (ECALL) SHALL enter HALT from DECODE with no register write and no retired increment.
REQ-031 In HALT, halted=1 and imem_req=0; only rst SHALL leave HALT.

Reset
REQ-032 On a clock edge with rst=1, the following SHALL be cleared: state to FETCH, PC=0, IR=0, A=0, B=0, result=0, every register=0, retired=0, illegal=0, halted=0.
REQ-033 imem_req SHALL be 0 during the reset cycle and SHALL go high on the first cycle after reset is released.
REQ-034 Reset in any state, including mid-fetch wait and HALT, SHALL abort the instruction in progress with no register write.
REQ-035 rst SHALL take priority over imem_valid arriving in the same cycle.

Structure
REQ-036 A shared package proc_pkg SHALL hold: the state enum, the ALU-op enum, the opcode constants (0110011, 0010011, ECALL word), and the funct3/funct7 constants.
REQ-037 A single sub-module alu_rv, parametrised by XLEN and purely combinational, SHALL implement the ALU; the register file, decode and FSM SHALL live in processor_multicycle.

Verification
REQ-038 Scenario: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 with imem_valid always high -> result=2, retired=3 at cycle 12.
REQ-039 Scenario: SUB x4,x1,x1 -> result=0 and zero=1; SLT x5,x2,x1 -> 1; SLTU x5,x2,x1 -> 0.
REQ-040 Scenario: ADDI x6,x0,-16 then SRAI x7,x6,2 -> 0xFFFFFFFC; SRLI x7,x6,28 -> 0xF (XLEN=32).
REQ-041 Scenario: imem_valid held low 3 cycles in FETCH -> imem_req held high throughout, instruction takes 7 cycles; a valid pulse in EXEC is ignored.
REQ-042 Scenario: ADDI x0,x0,9, then ADD x1,x0,x0 -> result=0; then opcode 0000000 -> illegal=1, PC advances by 4.
REQ-043 Scenario: ECALL -> halted=1, imem_req=0 and retired frozen for 10 cycles; then rst pulse -> PC=0, halted=0, fetch restarts.
